// File: rtl/result_signature_checker_pkg.sv
// Shared types and constants for the result signature checker.
//   state_t  : checker FSM states
//   OP_ALT / OP_BATT : values of the controller op_type bit
//   RSC_POLY / RSC_SEED : default MISR feedback polynomial and seed
package rsc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic OP_ALT  = 1'b0;
    localparam logic OP_BATT = 1'b1;

    localparam logic [15:0] RSC_POLY = 16'h1021;
    localparam logic [15:0] RSC_SEED = 16'h0000;

endpackage

// File: rtl/result_signature_checker_if.sv
// Controller result stream as seen by the signature checker.
//   in_data  : controller.out (signed result)
//   in_valid : controller.op_valid
//   in_type  : controller.op_type (0 = alt calc, 1 = batt calc)
// master drives the stream (controller side), slave consumes it.
interface result_signature_checker_if;

    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_type;

    modport master (output in_data, output in_valid, output in_type);
    modport slave  (input  in_data, input  in_valid, input  in_type);

endinterface

// File: rtl/result_signature_checker_misr16.sv
// 16-bit multiple-input signature register.
//   clk, reset : system clock, synchronous active-high reset (loads SEED)
//   load_seed  : synchronous reload of SEED (lower priority than reset)
//   step       : compact data into the signature this edge
//   data       : raw 16-bit input vector
//   sig        : current signature
module misr16 #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] SEED = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_seed,
    input  logic        step,
    input  logic [15:0] data,
    output logic [15:0] sig
);

    logic [15:0] sig_next;

    always_comb begin
        sig_next = {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ data;
    end

    always_ff @(posedge clk) begin
        if (reset || load_seed) begin
            sig <= SEED;
        end else if (step) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/result_signature_checker.sv
// Response analyzer for the shared-multiplier result stream.
// Compacts every accepted result into a MISR signature, counts alt/batt
// results, and after EXPECT_COUNT results compares against GOLDEN_SIG.
//   clk, reset  : system clock, synchronous active-high reset
//   enable      : BIST.enable_normal; results sampled only while high
//   clear       : synchronous restart of a collection
//   res         : result stream (in_data, in_valid, in_type)
//   signature   : current MISR value
//   alt_count   : accepted alt results (saturating)
//   batt_count  : accepted batt results (saturating)
//   last_result : most recently accepted in_data
//   done        : compare completed (sticky)
//   pass        : signature matched GOLDEN_SIG at compare time
//   overrun     : a valid arrived in COMPARE or DONE (sticky)
module result_signature_checker
    import rsc_pkg::*;
#(
    parameter int unsigned EXPECT_COUNT = 4,
    parameter logic [15:0] GOLDEN_SIG   = 16'hFEEE,
    parameter logic [15:0] SEED         = RSC_SEED,
    parameter logic [15:0] POLY         = RSC_POLY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear,
    result_signature_checker_if.slave     res,
    output logic [15:0]                   signature,
    output logic [7:0]                    alt_count,
    output logic [7:0]                    batt_count,
    output logic [15:0]                   last_result,
    output logic                          done,
    output logic                          pass,
    output logic                          overrun
);

    localparam logic [7:0] EXPECT_CNT8 = EXPECT_COUNT[7:0];

    state_t     state_q;
    state_t     state_d;
    logic [7:0] total_q;
    logic       accept;
    logic       overrun_set;

    misr16 #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk       (clk),
        .reset     (reset),
        .load_seed (clear),
        .step      (accept),
        .data      (res.in_data),
        .sig       (signature)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (enable && res.in_valid) begin
                    accept = 1'b1;
                    if (total_q + 8'd1 == EXPECT_CNT8) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                overrun_set = res.in_valid;
                state_d     = DONE;
            end
            DONE: begin
                overrun_set = res.in_valid;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= IDLE;
            total_q     <= '0;
            alt_count   <= '0;
            batt_count  <= '0;
            last_result <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_result <= res.in_data;
                total_q     <= total_q + 8'd1;
                if (res.in_type == OP_BATT) begin
                    if (batt_count != 8'hFF) begin
                        batt_count <= batt_count + 8'd1;
                    end
                end else begin
                    if (alt_count != 8'hFF) begin
                        alt_count <= alt_count + 8'd1;
                    end
                end
            end
            if (state_q == COMPARE) begin
                done <= 1'b1;
                pass <= (signature == GOLDEN_SIG);
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_signature_checker.sv
module tb_result_signature_checker;
    import rsc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_normal;
    logic        clear;
    logic [15:0] signature;
    logic [7:0]  alt_count;
    logic [7:0]  batt_count;
    logic [15:0] last_result;
    logic        done;
    logic        pass;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    result_signature_checker_if rif ();

    result_signature_checker #(
        .EXPECT_COUNT (4),
        .GOLDEN_SIG   (16'hFEEE),
        .SEED         (16'h0000),
        .POLY         (16'h1021)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable_normal),
        .clear       (clear),
        .res         (rif),
        .signature   (signature),
        .alt_count   (alt_count),
        .batt_count  (batt_count),
        .last_result (last_result),
        .done        (done),
        .pass        (pass),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] sig;
        logic [7:0]  alt;
        logic [7:0]  batt;
        logic [15:0] last;
        logic        dn;
        logic        ps;
        logic        ovr;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: compares every queued expectation against the outputs
    // sampled at the falling edge following the edge it describes.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (signature !== e.sig || alt_count !== e.alt || batt_count !== e.batt ||
                last_result !== e.last || done !== e.dn || pass !== e.ps || overrun !== e.ovr) begin
                errors++;
                $display("FAIL %s: got sig=%h alt=%0d batt=%0d last=%h done=%b pass=%b ovr=%b, expected sig=%h alt=%0d batt=%0d last=%h done=%b pass=%b ovr=%b",
                         e.name, signature, alt_count, batt_count, last_result, done, pass, overrun,
                         e.sig, e.alt, e.batt, e.last, e.dn, e.ps, e.ovr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [15:0] sig, input logic [7:0] alt,
                              input logic [7:0] batt, input logic [15:0] last,
                              input logic dn, input logic ps, input logic ovr);
        exp_t e;
        e.name = name; e.sig = sig; e.alt = alt; e.batt = batt; e.last = last;
        e.dn = dn; e.ps = ps; e.ovr = ovr;
        exp_q.push_back(e);
    endtask

    task automatic expect_reset_values(input string name);
        expect_out(name, 16'h0000, 8'd0, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [15:0] d, input logic t);
        rif.in_data  = d;
        rif.in_type  = t;
        rif.in_valid = 1'b1;
        tick();
        rif.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_reset_values("reset");
    endtask

    // Alt, batt, alt, batt stream; state must already be COLLECT with enable high.
    task automatic run_stream(input string name,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [15:0] s0, input logic [15:0] s1,
                              input logic [15:0] s2, input logic [15:0] s3,
                              input logic exp_pass);
        send(d0, OP_ALT);
        expect_out({name, "_r1"}, s0, 8'd1, 8'd0, d0, 1'b0, 1'b0, 1'b0);
        send(d1, OP_BATT);
        expect_out({name, "_r2"}, s1, 8'd1, 8'd1, d1, 1'b0, 1'b0, 1'b0);
        send(d2, OP_ALT);
        expect_out({name, "_r3"}, s2, 8'd2, 8'd1, d2, 1'b0, 1'b0, 1'b0);
        send(d3, OP_BATT);
        expect_out({name, "_compare"}, s3, 8'd2, 8'd2, d3, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out({name, "_done"}, s3, 8'd2, 8'd2, d3, 1'b1, exp_pass, 1'b0);
    endtask

    task automatic golden(input string name);
        run_stream(name, 16'd40, 16'd22, 16'd5, 16'hFFFC,
                   16'h0028, 16'h0046, 16'h0089, 16'hFEEE, 1'b1);
    endtask

    initial begin
        reset         = 1'b0;
        clear         = 1'b0;
        enable_normal = 1'b0;
        rif.in_data   = '0;
        rif.in_valid  = 1'b0;
        rif.in_type   = 1'b0;
        tick();

        // Golden pass
        do_reset();
        enable_normal = 1'b1;
        tick();
        expect_reset_values("idle_to_collect");
        golden("golden");

        // Overrun after done
        send(16'd1, OP_ALT);
        expect_out("overrun", 16'hFEEE, 8'd2, 8'd2, 16'hFFFC, 1'b1, 1'b1, 1'b1);
        tick();
        expect_out("done_hold", 16'hFEEE, 8'd2, 8'd2, 16'hFFFC, 1'b1, 1'b1, 1'b1);

        // Clear together with valid: clear wins
        clear = 1'b1;
        rif.in_valid = 1'b1;
        rif.in_data  = 16'h1234;
        tick();
        clear = 1'b0;
        rif.in_valid = 1'b0;
        expect_reset_values("clear_with_valid");

        // Failing stream (24 replaces 40)
        tick();
        run_stream("fail", 16'd24, 16'd22, 16'd5, 16'hFFFC,
                   16'h0018, 16'h0026, 16'h0049, 16'hFF6E, 1'b0);

        // Enable gating: valids with enable low are ignored
        do_reset();
        enable_normal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(16'h00AA + 16'(i), OP_BATT);
            expect_reset_values("gated_valid");
        end
        enable_normal = 1'b1;
        tick();
        golden("after_gate");

        // Mid-stream stall
        do_reset();
        tick();
        send(16'd40, OP_ALT);
        send(16'd22, OP_BATT);
        expect_out("stall_pre", 16'h0046, 8'd1, 8'd1, 16'h0016, 1'b0, 1'b0, 1'b0);
        enable_normal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(16'h0100 + 16'(i), OP_ALT);
            expect_out("stall_hold", 16'h0046, 8'd1, 8'd1, 16'h0016, 1'b0, 1'b0, 1'b0);
        end
        enable_normal = 1'b1;
        send(16'd5, OP_ALT);
        expect_out("stall_r3", 16'h0089, 8'd2, 8'd1, 16'h0005, 1'b0, 1'b0, 1'b0);
        send(16'hFFFC, OP_BATT);
        tick();
        expect_out("stall_done", 16'hFEEE, 8'd2, 8'd2, 16'hFFFC, 1'b1, 1'b1, 1'b0);

        // Reset mid-collection
        do_reset();
        tick();
        send(16'd40, OP_ALT);
        send(16'd22, OP_BATT);
        reset = 1'b1;
        rif.in_valid = 1'b1;
        rif.in_data  = 16'd5;
        tick();
        reset = 1'b0;
        rif.in_valid = 1'b0;
        expect_reset_values("reset_mid");
        tick();
        golden("after_reset");

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
